// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared write-back select and load-type encodings
package cpu_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_H  = 3'd1,
        LD_HU = 3'd2,
        LD_B  = 3'd3,
        LD_BU = 3'd4
    } ld_type_e;

    // Everything the WB stage keeps about one instruction
    typedef struct packed {
        logic        reg_write;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic [2:0]  ld_type;
        logic [1:0]  addr_lo;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
    } wb_regs_t;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-to-WB bundle and register file write port
interface wb_stage_if;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_ld_type;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu;
    logic [31:0] mem_rdata;
    logic [31:0] mem_pc4;
    logic [4:0]  Wt_addr;
    logic [31:0] wt_data;
    logic        L_S;
    logic        wb_valid;
    logic        wb_misalign;
    logic [31:0] instret;

    modport master (
        output stall, flush, mem_valid, mem_reg_write, mem_rd, mem_wb_sel,
               mem_ld_type, mem_addr_lo, mem_alu, mem_rdata, mem_pc4,
        input  Wt_addr, wt_data, L_S, wb_valid, wb_misalign, instret
    );

    modport slave (
        input  stall, flush, mem_valid, mem_reg_write, mem_rd, mem_wb_sel,
               mem_ld_type, mem_addr_lo, mem_alu, mem_rdata, mem_pc4,
        output Wt_addr, wt_data, L_S, wb_valid, wb_misalign, instret
    );
endinterface

// File: rtl/wb_stage_load_extract.sv
// rtl/wb_stage_load_extract.sv - combinational load lane select, extension and alignment check
module load_extract
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_type,
    output logic [31:0] data,
    output logic        misalign
);

    logic [15:0] half_sel;
    logic [7:0]  b_sel;

    always_comb begin
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd0:    b_sel = rdata[7:0];
            2'd1:    b_sel = rdata[15:8];
            2'd2:    b_sel = rdata[23:16];
            default: b_sel = rdata[31:24];
        endcase
    end

    // Unknown load types fall back to a full word access
    always_comb begin
        data     = rdata;
        misalign = 1'b0;
        case (ld_type)
            LD_H: begin
                data     = {{16{half_sel[15]}}, half_sel};
                misalign = addr_lo[0];
            end
            LD_HU: begin
                data     = {16'h0000, half_sel};
                misalign = addr_lo[0];
            end
            LD_B:    data = {{24{b_sel[7]}}, b_sel};
            LD_BU:   data = {24'h00_0000, b_sel};
            default: misalign = (addr_lo != 2'd0);
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register, write-back mux and retire counter
module wb_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC4 = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    wb_stage_if.slave  bus
);

    wb_regs_t    wb_q;
    logic        valid_q;
    logic        fresh_q;
    logic [31:0] cnt_q;

    logic [31:0] ld_data;
    logic        ld_misalign;
    logic        misaligned;
    logic        write_en;
    logic        retire;
    logic [31:0] src_data;

    load_extract u_load_extract (
        .rdata    (wb_q.rdata),
        .addr_lo  (wb_q.addr_lo),
        .ld_type  (wb_q.ld_type),
        .data     (ld_data),
        .misalign (ld_misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            fresh_q     <= 1'b0;
            cnt_q       <= 32'h0;
            wb_q        <= '0;
            wb_q.pc4    <= RESET_PC4;
        end else begin
            cnt_q <= cnt_q + {31'h0, retire};
            if (bus.flush) begin
                valid_q <= 1'b0;
                fresh_q <= 1'b0;
            end else if (bus.stall) begin
                fresh_q <= 1'b0;
            end else begin
                valid_q           <= bus.mem_valid;
                fresh_q           <= bus.mem_valid;
                wb_q.reg_write    <= bus.mem_reg_write;
                wb_q.rd           <= bus.mem_rd;
                wb_q.wb_sel       <= bus.mem_wb_sel;
                wb_q.ld_type      <= bus.mem_ld_type;
                wb_q.addr_lo      <= bus.mem_addr_lo;
                wb_q.alu          <= bus.mem_alu;
                wb_q.rdata        <= bus.mem_rdata;
                wb_q.pc4          <= bus.mem_pc4;
            end
        end
    end

    always_comb begin
        misaligned = valid_q && (wb_q.wb_sel == WB_LOAD) && ld_misalign;
        write_en   = valid_q && wb_q.reg_write && (wb_q.rd != 5'd0) && !misaligned;
        retire     = valid_q && fresh_q && !misaligned;
        case (wb_q.wb_sel)
            WB_ALU:  src_data = wb_q.alu;
            WB_LOAD: src_data = ld_data;
            WB_PC4:  src_data = wb_q.pc4;
            default: src_data = 32'h0;
        endcase
    end

    // The counter output already includes the instruction retiring this cycle
    assign bus.Wt_addr     = wb_q.rd;
    assign bus.wt_data     = write_en ? src_data : 32'h0;
    assign bus.L_S         = write_en;
    assign bus.wb_valid    = valid_q;
    assign bus.wb_misalign = valid_q && fresh_q && misaligned;
    assign bus.instret     = cnt_q + {31'h0, retire};

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  ld;
        logic [1:0]  a;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
    } ins_t;

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  ld;
        logic [1:0]  a;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] d;
        logic        ls;
        logic        mis;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_stage_if bus();

    wb_stage #(.RESET_PC4(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] cnt_exp;
    ins_t cur, nin, idle;
    logic fresh;
    logic st, fl;
    logic [31:0] ed;
    logic el, em;
    vec_t tv[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input ins_t i, input logic s, input logic f);
        bus.stall         = s;
        bus.flush         = f;
        bus.mem_valid     = i.v;
        bus.mem_reg_write = i.rw;
        bus.mem_rd        = i.rd;
        bus.mem_wb_sel    = i.sel;
        bus.mem_ld_type   = i.ld;
        bus.mem_addr_lo   = i.a;
        bus.mem_alu       = i.alu;
        bus.mem_rdata     = i.rdata;
        bus.mem_pc4       = i.pc4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t,
                                     output logic [31:0] d, output logic m);
        logic [31:0] h, b;
        h = (w >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
        b = (w >> (8 * int'(a))) & 32'h0000_00FF;
        case (t)
            3'd1: begin d = h[15] ? (h | 32'hFFFF_0000) : h; m = a[0]; end
            3'd2: begin d = h; m = a[0]; end
            3'd3: begin d = b[7] ? (b | 32'hFFFF_FF00) : b; m = 1'b0; end
            3'd4: begin d = b; m = 1'b0; end
            default: begin d = w; m = (a != 2'd0); end
        endcase
    endfunction

    function automatic void ref_out(input ins_t i, output logic [31:0] d, output logic ls, output logic mis);
        logic [31:0] ldd, src;
        logic lm;
        ref_load(i.rdata, i.a, i.ld, ldd, lm);
        mis = i.v && (i.sel == 2'd1) && lm;
        case (i.sel)
            2'd0:    src = i.alu;
            2'd1:    src = ldd;
            2'd2:    src = i.pc4;
            default: src = 32'h0;
        endcase
        ls = i.v && i.rw && (i.rd != 5'd0) && !mis;
        d  = ls ? src : 32'h0;
    endfunction

    task automatic chk_all(input string tag, input logic v, input logic [31:0] d, input logic ls,
                           input logic [4:0] rd, input logic mis, input logic [31:0] cnt);
        chk({tag, " wb_valid"}, {31'h0, bus.wb_valid}, {31'h0, v});
        chk({tag, " L_S"}, {31'h0, bus.L_S}, {31'h0, ls});
        chk({tag, " wt_data"}, bus.wt_data, d);
        if (ls) chk({tag, " Wt_addr"}, {27'h0, bus.Wt_addr}, {27'h0, rd});
        chk({tag, " wb_misalign"}, {31'h0, bus.wb_misalign}, {31'h0, mis});
        chk({tag, " instret"}, bus.instret, cnt);
    endtask

    initial begin
        idle = '{1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0};
        drive(idle, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        step();
        chk("reset Wt_addr", {27'h0, bus.Wt_addr}, 32'h0);
        chk_all("reset", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cnt_exp = 32'h0;

        tv[0]  = '{2'd0, 3'd0, 2'd0, 5'd5,  1'b1, 32'h1234_5678, 1'b1, 1'b0};
        tv[1]  = '{2'd1, 3'd3, 2'd3, 5'd6,  1'b1, 32'hFFFF_FF80, 1'b1, 1'b0};
        tv[2]  = '{2'd1, 3'd4, 2'd1, 5'd7,  1'b1, 32'h0000_007F, 1'b1, 1'b0};
        tv[3]  = '{2'd1, 3'd1, 2'd2, 5'd8,  1'b1, 32'hFFFF_80FF, 1'b1, 1'b0};
        tv[4]  = '{2'd1, 3'd2, 2'd0, 5'd9,  1'b1, 32'h0000_7F01, 1'b1, 1'b0};
        tv[5]  = '{2'd1, 3'd0, 2'd2, 5'd10, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
        tv[6]  = '{2'd1, 3'd0, 2'd0, 5'd11, 1'b1, 32'h80FF_7F01, 1'b1, 1'b0};
        tv[7]  = '{2'd1, 3'd1, 2'd1, 5'd12, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
        tv[8]  = '{2'd1, 3'd3, 2'd1, 5'd13, 1'b1, 32'h0000_007F, 1'b1, 1'b0};
        tv[9]  = '{2'd2, 3'd0, 2'd0, 5'd31, 1'b1, 32'h0000_0040, 1'b1, 1'b0};
        tv[10] = '{2'd3, 3'd0, 2'd0, 5'd14, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tv[11] = '{2'd0, 3'd0, 2'd0, 5'd0,  1'b1, 32'h0000_0000, 1'b0, 1'b0};
        tv[12] = '{2'd1, 3'd6, 2'd0, 5'd15, 1'b1, 32'h80FF_7F01, 1'b1, 1'b0};
        tv[13] = '{2'd0, 3'd0, 2'd2, 5'd16, 1'b1, 32'h1234_5678, 1'b1, 1'b0};
        tv[14] = '{2'd0, 3'd0, 2'd0, 5'd17, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tv[15] = '{2'd1, 3'd2, 2'd3, 5'd18, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
        tv[16] = '{2'd1, 3'd4, 2'd2, 5'd19, 1'b1, 32'h0000_00FF, 1'b1, 1'b0};

        for (int i = 0; i < 17; i++) begin
            nin = '{1'b1, tv[i].rw, tv[i].rd, tv[i].sel, tv[i].ld, tv[i].a,
                    32'h1234_5678, 32'h80FF_7F01, 32'h0000_0040};
            drive(nin, 1'b0, 1'b0);
            step();
            if (!tv[i].mis) cnt_exp++;
            chk_all($sformatf("vec%0d", i), 1'b1, tv[i].d, tv[i].ls, tv[i].rd, tv[i].mis, cnt_exp);
        end

        // jal held by a three-cycle stall: one retire, four cycles of write
        nin = '{1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0000_0040};
        drive(nin, 1'b0, 1'b0);
        step();
        cnt_exp++;
        chk_all("stall c0", 1'b1, 32'h40, 1'b1, 5'd31, 1'b0, cnt_exp);
        nin = '{1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 2'd0, 32'h5555_AAAA, 32'h0, 32'h0};
        for (int i = 1; i < 4; i++) begin
            drive(nin, 1'b1, 1'b0);
            step();
            chk_all($sformatf("stall c%0d", i), 1'b1, 32'h40, 1'b1, 5'd31, 1'b0, cnt_exp);
        end
        drive(nin, 1'b1, 1'b1);
        step();
        chk_all("flush+stall", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, cnt_exp);

        // misaligned load pulses once even when held
        nin = '{1'b1, 1'b1, 5'd9, 2'd1, 3'd0, 2'd2, 32'h0, 32'h80FF_7F01, 32'h0};
        drive(nin, 1'b0, 1'b0);
        step();
        chk_all("mis c0", 1'b1, 32'h0, 1'b0, 5'd9, 1'b1, cnt_exp);
        drive(nin, 1'b1, 1'b0);
        step();
        chk_all("mis c1", 1'b1, 32'h0, 1'b0, 5'd9, 1'b0, cnt_exp);

        // asynchronous reset in the middle of a write cycle
        nin = '{1'b1, 1'b1, 5'd4, 2'd0, 3'd0, 2'd0, 32'hCAFE_F00D, 32'h0, 32'h0};
        drive(nin, 1'b0, 1'b0);
        step();
        cnt_exp++;
        chk_all("pre-rst", 1'b1, 32'hCAFE_F00D, 1'b1, 5'd4, 1'b0, cnt_exp);
        drive(idle, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async rst Wt_addr", {27'h0, bus.Wt_addr}, 32'h0);
        chk_all("async rst", 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cnt_exp = 32'h0;
        step();

        // counter wrap
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        chk("preload instret", bus.instret, 32'hFFFF_FFFF);
        nin = '{1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 2'd0, 32'h0000_0077, 32'h0, 32'h0};
        drive(nin, 1'b0, 1'b0);
        step();
        chk_all("wrap", 1'b1, 32'h77, 1'b1, 5'd3, 1'b0, 32'h0);
        drive(idle, 1'b0, 1'b0);
        step();
        chk("wrap hold instret", bus.instret, 32'h0);

        // randomized traffic against the reference model
        cnt_exp = 32'h0;
        cur = idle;
        fresh = 1'b0;
        for (int k = 0; k < 400; k++) begin
            nin.v     = ($urandom_range(3) != 0);
            nin.rw    = ($urandom_range(7) != 0);
            nin.rd    = 5'($urandom_range(31));
            nin.sel   = 2'($urandom_range(3));
            nin.ld    = 3'($urandom_range(7));
            nin.a     = 2'($urandom_range(3));
            nin.alu   = $urandom;
            nin.rdata = $urandom;
            nin.pc4   = $urandom;
            st = ($urandom_range(3) == 0);
            fl = ($urandom_range(9) == 0);
            drive(nin, st, fl);
            if (fl) begin
                cur.v = 1'b0;
                fresh = 1'b0;
            end else if (st) begin
                fresh = 1'b0;
            end else begin
                cur   = nin;
                fresh = nin.v;
                ref_out(nin, ed, el, em);
                if (nin.v && !em) cnt_exp++;
            end
            step();
            ref_out(cur, ed, el, em);
            chk_all($sformatf("rnd%0d", k), cur.v, ed, el, cur.rd, fresh && em, cnt_exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
